qos_write_controller: RTL and testbench
=======================================

Name: qos_write_controller

Overview:
- Producer/enqueue end of the QoS queuing path.
- Turns active-low pushbutton presses (start, button0, button1) into 4-bit packets and pushes each packet into one of four 3-entry priority buffers, selected by the packet's upper two bits.
- Exposes the packed 12-bit buffer images and a registered pop port, which the downstream read scheduler uses to drain entries.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each button input (minimum 2).
- DEBOUNCE_CYCLES, 1000, number of stable cycles required before a press is accepted (used only with DEBOUNCE_EN).
- DROP_W, 8, width of each per-buffer drop counter (saturating).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  active-low button; begins a new packet
- button0  in  1  active-low button; enters bit value 0
- button1  in  1  active-low button; enters bit value 1
- pop_req  in  1  one-cycle pop request from the reader
- pop_sel  in  2  buffer to pop (00 = buffer1 … 11 = buffer4)
- pop_ack  out  1  one-cycle acknowledge, the cycle after pop_req
- pop_empty  out  1  qualifies pop_ack; selected buffer was empty
- pop_data  out  4  popped nibble; 0 when empty
- buffer1_12bit … buffer4_12bit  out  12 each  packed buffer images
- count1 … count4  out  2 each  occupancy, 0..3
- drop1 … drop4  out  DROP_W each  overwrite counts
- entry_bits  out  4  packet being assembled, for display
- entry_idx  out  3  bits entered so far, 0..4
- store_valid  out  1  one-cycle pulse on commit
- stored_data  out  4  last committed packet

Behaviour:
- Reset (async, active-low): all outputs, buffers, counters, synchronizers and FSM clear to 0. FSM goes to IDLE. A reset mid-packet discards the partial packet.
- Input conditioning:
  - Each button passes through SYNC_STAGES flops.
  - A press is a 1→0 transition of the synchronized level, producing a one-cycle pulse.
  - Latency from pin to pulse is SYNC_STAGES+1 cycles.
- FSM states: IDLE, COLLECT, COMMIT.
  - IDLE: start pulse → COLLECT with entry_idx=0, entry_bits=0. bit pulses are ignored.
  - COLLECT: a bit pulse shifts in MSB-first (entry_bits <= {entry_bits[2:0], b}) and increments entry_idx. When entry_idx reaches 4 → COMMIT.
  - COLLECT: a start pulse restarts the packet (entry_idx=0, entry_bits=0).
  - COLLECT: button0 and button1 pulses in the same cycle are both ignored.
  - COMMIT (one cycle): write the packet, pulse store_valid, set stored_data=entry_bits, then → IDLE. entry_idx holds 4 until the next start.
- Packet format:
  - bits[3:2] select the buffer (00 = buffer1 … 11 = buffer4).
  - The whole 4-bit packet is stored as the entry.
- Buffer layout:
  - slot0 = [3:0] (oldest), slot1 = [7:4], slot2 = [11:8].
  - Unoccupied slots always read 0.
  - A push writes slot[count] and increments count.
- Full (count = 3) push:
  - Drop the oldest entry: shift down, new entry goes to slot2, count stays 3.
  - drop counter increments and saturates at all-ones.
- Pop:
  - pop_req is sampled on clk. Next cycle pop_ack=1 and pop_data=slot0.
  - Slots shift down, the vacated top slot becomes 0, and count decrements.
  - Empty buffer: pop_ack=1, pop_empty=1, pop_data=0, no state change.
  - pop_ack and pop_empty are low in all other cycles.
- Pop and commit to the same buffer in the same cycle: pop is applied first, then push.
  - A full buffer therefore incurs no drop; count stays 3.
  - pop_data is the pre-shift slot0.
- Pop and commit to different buffers in the same cycle: both take effect independently.

Optional Feature:
- Macro: QOS_WRITE_DEBOUNCE_EN.
- Defined: each synchronized button level must be stable for DEBOUNCE_CYCLES consecutive cycles before its debounced level updates. Edge detection uses the debounced level, so press latency is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: no debounce logic is instantiated; the edge detector uses the synchronizer output directly.

Test Plan:
1. Reset low, then high; press start, 0, 0, 1, 1 → store_valid pulse, stored_data=4'h3, buffer1_12bit=12'h003, count1=1, others 0.
2. Continue with start+0001, then start+0010 → buffer1_12bit=12'h213, count1=3, drop1=0.
3. Then start+0000 → buffer1_12bit=12'h021, count1=3, drop1=1 (oldest 3 dropped).
4. pop_req with pop_sel=00 → next cycle pop_ack=1, pop_data=4'h1, buffer1_12bit=12'h002, count1=2. pop_sel=01 on empty buffer2 → pop_ack=1, pop_empty=1, pop_data=0.
5. Start+0,1 then start+1,1,0,1 → only 4'hD committed: buffer4_12bit=12'h00D. Simultaneous button0/button1 press → entry_idx unchanged. Reset asserted mid-COLLECT → all outputs 0 asynchronously.
6. Fill buffer3 to 3 entries; commit a 4th packet to buffer3 in the same cycle as pop_sel=10 → pop_data = old slot0, count3=3, drop3=0. With QOS_WRITE_DEBOUNCE_EN defined, a 10-cycle glitch on button1 → no bit entered.

Source files
------------

// File: rtl/qos_write_controller.sv
// Enqueue side of the QoS path: button presses -> 4-bit packets -> four 3-deep priority buffers.
// Optional input debounce is compiled in with `define QOS_WRITE_DEBOUNCE_EN.
module qos_write_controller #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DROP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              button0,
  input  logic              button1,
  input  logic              pop_req,
  input  logic [1:0]        pop_sel,
  output logic              pop_ack,
  output logic              pop_empty,
  output logic [3:0]        pop_data,
  output logic [11:0]       buffer1_12bit,
  output logic [11:0]       buffer2_12bit,
  output logic [11:0]       buffer3_12bit,
  output logic [11:0]       buffer4_12bit,
  output logic [1:0]        count1,
  output logic [1:0]        count2,
  output logic [1:0]        count3,
  output logic [1:0]        count4,
  output logic [DROP_W-1:0] drop1,
  output logic [DROP_W-1:0] drop2,
  output logic [DROP_W-1:0] drop3,
  output logic [DROP_W-1:0] drop4,
  output logic [3:0]        entry_bits,
  output logic [2:0]        entry_idx,
  output logic              store_valid,
  output logic [3:0]        stored_data
);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  logic [2:0]             btn_in;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             lvl;
  logic [2:0]             clean;
  logic [2:0]             prev_q;
  logic [2:0]             pulse_q;

  assign btn_in = {button1, button0, start};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_in[i]};
    end
  end

  always_comb begin
    lvl = '0;
    for (int i = 0; i < 3; i++) lvl[i] = sync_q[i][SYNC_STAGES-1];
  end

`ifdef QOS_WRITE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [2:0]       db_q;

  // Debounced level follows the synchronized level only after it has held for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (lvl[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= lvl[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign clean = db_q;
`else
  assign clean = lvl;
`endif

  // Press = falling edge of the conditioned level, registered into a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      prev_q  <= clean;
      pulse_q <= prev_q & ~clean;
    end
  end

  logic start_p, b0_p, b1_p;
  assign start_p = pulse_q[0];
  assign b0_p    = pulse_q[1];
  assign b1_p    = pulse_q[2];

  state_t     state_q;
  logic [3:0] entry_bits_q;
  logic [2:0] entry_idx_q;
  logic       store_valid_q;
  logic [3:0] stored_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      entry_bits_q  <= '0;
      entry_idx_q   <= '0;
      store_valid_q <= 1'b0;
      stored_data_q <= '0;
    end else begin
      store_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_p) begin
            state_q      <= COLLECT;
            entry_bits_q <= '0;
            entry_idx_q  <= '0;
          end
        end
        COLLECT: begin
          if (start_p) begin
            entry_bits_q <= '0;
            entry_idx_q  <= '0;
          end else if (b0_p ^ b1_p) begin
            entry_bits_q <= {entry_bits_q[2:0], b1_p};
            entry_idx_q  <= entry_idx_q + 3'd1;
            if (entry_idx_q == 3'd3) state_q <= COMMIT;
          end
        end
        COMMIT: begin
          store_valid_q <= 1'b1;
          stored_data_q <= entry_bits_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic              push;
  logic [11:0]       buf_q   [4];
  logic [11:0]       buf_d   [4];
  logic [1:0]        cnt_q   [4];
  logic [1:0]        cnt_d   [4];
  logic [DROP_W-1:0] drop_q  [4];
  logic [DROP_W-1:0] drop_d  [4];
  logic              pop_ack_q, pop_empty_q;
  logic [3:0]        pop_data_q;

  assign push = (state_q == COMMIT);

  // Pop is applied before push, so a same-cycle pop makes room and a full buffer never drops.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      buf_d[b]  = buf_q[b];
      cnt_d[b]  = cnt_q[b];
      drop_d[b] = drop_q[b];
      if (pop_req && (pop_sel == 2'(b)) && (cnt_q[b] != 2'd0)) begin
        buf_d[b] = {4'h0, buf_q[b][11:4]};
        cnt_d[b] = cnt_q[b] - 2'd1;
      end
      if (push && (entry_bits_q[3:2] == 2'(b))) begin
        case (cnt_d[b])
          2'd0: buf_d[b][3:0]  = entry_bits_q;
          2'd1: buf_d[b][7:4]  = entry_bits_q;
          2'd2: buf_d[b][11:8] = entry_bits_q;
          default: begin
            buf_d[b] = {entry_bits_q, buf_d[b][11:4]};
            if (drop_d[b] != {DROP_W{1'b1}}) drop_d[b] = drop_d[b] + DROP_W'(1);
          end
        endcase
        if (cnt_d[b] != 2'd3) cnt_d[b] = cnt_d[b] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 4; b++) begin
        buf_q[b]  <= '0;
        cnt_q[b]  <= '0;
        drop_q[b] <= '0;
      end
      pop_ack_q   <= 1'b0;
      pop_empty_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        buf_q[b]  <= buf_d[b];
        cnt_q[b]  <= cnt_d[b];
        drop_q[b] <= drop_d[b];
      end
      pop_ack_q   <= pop_req;
      pop_empty_q <= pop_req && (cnt_q[pop_sel] == 2'd0);
      pop_data_q  <= pop_req ? buf_q[pop_sel][3:0] : 4'h0;
    end
  end

  assign pop_ack       = pop_ack_q;
  assign pop_empty     = pop_empty_q;
  assign pop_data      = pop_data_q;
  assign buffer1_12bit = buf_q[0];
  assign buffer2_12bit = buf_q[1];
  assign buffer3_12bit = buf_q[2];
  assign buffer4_12bit = buf_q[3];
  assign count1        = cnt_q[0];
  assign count2        = cnt_q[1];
  assign count3        = cnt_q[2];
  assign count4        = cnt_q[3];
  assign drop1         = drop_q[0];
  assign drop2         = drop_q[1];
  assign drop3         = drop_q[2];
  assign drop4         = drop_q[3];
  assign entry_bits    = entry_bits_q;
  assign entry_idx     = entry_idx_q;
  assign store_valid   = store_valid_q;
  assign stored_data   = stored_data_q;

endmodule

// File: tb/tb_qos_write_controller.sv
// Directed bench for qos_write_controller: packet entry, buffer fill/drop, pop, reset, pop+commit.
module tb_qos_write_controller;

  localparam int D = 20;
`ifdef QOS_WRITE_DEBOUNCE_EN
  localparam int LAT  = 3 + D;
  localparam int HOLD = D + 4;
  localparam int GAP  = D + 8;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
  localparam int GAP  = 6;
`endif

  logic clk, reset, start, button0, button1, pop_req;
  logic [1:0]  pop_sel;
  logic        pop_ack, pop_empty, store_valid;
  logic [3:0]  pop_data, entry_bits, stored_data;
  logic [11:0] buffer1_12bit, buffer2_12bit, buffer3_12bit, buffer4_12bit;
  logic [1:0]  count1, count2, count3, count4;
  logic [1:0]  drop1, drop2, drop3, drop4;
  logic [2:0]  entry_idx;

  qos_write_controller #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .DROP_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .button0(button0), .button1(button1),
    .pop_req(pop_req), .pop_sel(pop_sel), .pop_ack(pop_ack), .pop_empty(pop_empty),
    .pop_data(pop_data),
    .buffer1_12bit(buffer1_12bit), .buffer2_12bit(buffer2_12bit),
    .buffer3_12bit(buffer3_12bit), .buffer4_12bit(buffer4_12bit),
    .count1(count1), .count2(count2), .count3(count3), .count4(count4),
    .drop1(drop1), .drop2(drop2), .drop3(drop3), .drop4(drop4),
    .entry_bits(entry_bits), .entry_idx(entry_idx),
    .store_valid(store_valid), .stored_data(stored_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared, mismatched, sv_count, sv_before;
  logic [3:0] sv_last;

  always @(posedge clk) begin
    #1;
    if (store_valid === 1'b1) begin
      sv_count = sv_count + 1;
      sv_last  = stored_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = start, 1 = button0, 2 = button1, 3 = button0+button1 together
  task automatic press(input int which);
    @(negedge clk);
    start   = (which == 0) ? 1'b0 : 1'b1;
    button0 = (which == 1 || which == 3) ? 1'b0 : 1'b1;
    button1 = (which == 2 || which == 3) ? 1'b0 : 1'b1;
    repeat (HOLD) @(negedge clk);
    start = 1'b1; button0 = 1'b1; button1 = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send(input logic [3:0] p);
    press(0);
    for (int i = 3; i >= 0; i--) press(p[i] ? 2 : 1);
  endtask

  task automatic pop(input logic [1:0] sel);
    @(negedge clk);
    pop_req = 1'b1; pop_sel = sel;
    @(negedge clk);
    pop_req = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0; sv_count = 0; sv_last = 4'h0;
    reset = 1'b0; start = 1'b1; button0 = 1'b1; button1 = 1'b1;
    pop_req = 1'b0; pop_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_entry_idx", entry_idx, 0);
    check("rst_store_valid", store_valid, 0);
    check("rst_buffer1", buffer1_12bit, 0);
    check("rst_pop_ack", pop_ack, 0);
    check("rst_stored_data", stored_data, 0);
    reset = 1'b1;
    repeat (GAP) @(negedge clk);
    check("no_pulse_after_reset", sv_count, 0);

    send(4'h3);
    check("t1_sv_count", sv_count, 1);
    check("t1_sv_data", sv_last, 4'h3);
    check("t1_stored_data", stored_data, 4'h3);
    check("t1_buffer1", buffer1_12bit, 12'h003);
    check("t1_count1", count1, 1);
    check("t1_buffer2", buffer2_12bit, 0);
    check("t1_count2", count2, 0);
    check("t1_entry_idx", entry_idx, 4);

    send(4'h1);
    send(4'h2);
    check("t2_buffer1", buffer1_12bit, 12'h213);
    check("t2_count1", count1, 3);
    check("t2_drop1", drop1, 0);

    send(4'h0);
    check("t3_buffer1", buffer1_12bit, 12'h021);
    check("t3_count1", count1, 3);
    check("t3_drop1", drop1, 1);

    pop(2'd0);
    check("t4_pop_ack", pop_ack, 1);
    check("t4_pop_empty", pop_empty, 0);
    check("t4_pop_data", pop_data, 4'h1);
    check("t4_buffer1", buffer1_12bit, 12'h002);
    check("t4_count1", count1, 2);
    @(negedge clk);
    check("t4_ack_low", pop_ack, 0);
    pop(2'd1);
    check("t4e_pop_ack", pop_ack, 1);
    check("t4e_pop_empty", pop_empty, 1);
    check("t4e_pop_data", pop_data, 0);
    check("t4e_count2", count2, 0);

    send(4'h0);
    check("sat_fill_count1", count1, 3);
    check("sat_fill_drop1", drop1, 1);
    send(4'h0);
    send(4'h0);
    send(4'h0);
    check("sat_drop1", drop1, 3);
    check("sat_buffer1", buffer1_12bit, 12'h000);
    check("sat_count1", count1, 3);

    sv_before = sv_count;
    press(0); press(1); press(2);
    send(4'hD);
    check("t5_one_commit", sv_count, sv_before + 1);
    check("t5_buffer4", buffer4_12bit, 12'h00D);
    check("t5_count4", count4, 1);
    check("t5_stored_data", stored_data, 4'hD);

    press(0);
    press(3);
    check("t5_both_idx", entry_idx, 0);
    press(2);
    check("t5_bit_idx", entry_idx, 1);
    check("t5_bit_bits", entry_bits, 4'h1);

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_entry_idx", entry_idx, 0);
    check("arst_entry_bits", entry_bits, 0);
    check("arst_buffer4", buffer4_12bit, 0);
    check("arst_count4", count4, 0);
    check("arst_drop1", drop1, 0);
    check("arst_stored_data", stored_data, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (GAP) @(negedge clk);

    send(4'h8);
    send(4'h9);
    send(4'hA);
    check("t6_buffer3_full", buffer3_12bit, 12'hA98);
    check("t6_count3_full", count3, 3);
    sv_before = sv_count;
    press(0); press(2); press(1); press(2);
    @(negedge clk);
    button1 = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    pop_req = 1'b1; pop_sel = 2'd2;
    @(negedge clk);
    pop_req = 1'b0;
    check("t6_pop_ack", pop_ack, 1);
    check("t6_pop_empty", pop_empty, 0);
    check("t6_pop_data", pop_data, 4'h8);
    check("t6_store_valid", store_valid, 1);
    check("t6_commit_count", sv_count, sv_before + 1);
    check("t6_buffer3", buffer3_12bit, 12'hBA9);
    check("t6_count3", count3, 3);
    check("t6_drop3", drop3, 0);
    button1 = 1'b1;
    repeat (GAP) @(negedge clk);

`ifdef QOS_WRITE_DEBOUNCE_EN
    press(0);
    check("glitch_pre_idx", entry_idx, 0);
    @(negedge clk);
    button1 = 1'b0;
    repeat (10) @(negedge clk);
    button1 = 1'b1;
    repeat (GAP) @(negedge clk);
    check("glitch_idx", entry_idx, 0);
    check("glitch_bits", entry_bits, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
